// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and the iteration-counter width helper.
package mult_div_pkg;

    localparam int unsigned MD_DATA_WIDTH = 32;

    // Counter width for a given operand width (counts 0 .. width-1).
    function automatic int unsigned md_cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

    localparam int unsigned MD_CNT_WIDTH = md_cnt_width(MD_DATA_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        CALC,
        FIX
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide datapath.
// Multiply: shift-add, {acc_hi, acc_lo} holds {partial product, multiplier}.
// Divide: restoring shift-subtract, {acc_hi, acc_lo} holds {remainder, dividend/quotient}.
module mult_div_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] acc_hi,
    input  logic [DATA_WIDTH-1:0] acc_lo,
    input  logic [DATA_WIDTH-1:0] opnd,
    output logic [DATA_WIDTH-1:0] next_hi,
    output logic [DATA_WIDTH-1:0] next_lo
);

    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH-1:0] rem_sub;
    logic                  fits;

    // Single-iteration combinational step, selected by operation class.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        shifted = {acc_hi, acc_lo[DATA_WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        // When the divisor fits, the true difference is below 2^W, so the
        // W-bit wrap-around subtraction is exact.
        rem_sub = shifted[DATA_WIDTH-1:0] - opnd;
        next_hi = '0;
        next_lo = '0;
        if (is_div) begin
            if (fits) begin
                next_hi = rem_sub;
                next_lo = {acc_lo[DATA_WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[DATA_WIDTH-1:0];
                next_lo = {acc_lo[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            {next_hi, next_lo} = {sum, acc_lo[DATA_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO.
// Optional macro MULT_DIV_FAST_MULT_EN: single-cycle combinational multiply
// (IDLE -> FIX); division always iterates.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  hi_we_i,
    input  logic                  lo_we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_WIDTH = md_cnt_width(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    md_state_e             state_q, state_d;
    md_op_e                op_q;
    logic [DATA_WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  neg_lo_q, neg_hi_q, dbz_q;
    logic                  busy_q, done_q;

    logic                  accept;
    logic                  sign_a, sign_b;
    logic [DATA_WIDTH-1:0] abs_a, abs_b;
    logic [DATA_WIDTH-1:0] step_hi, step_lo;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] res_hi, res_lo;

    assign accept = (state_q == IDLE) && start_i && !flush_i;

`ifdef MULT_DIV_FAST_MULT_EN
    logic [2*DATA_WIDTH-1:0] ext_a, ext_b, fast_prod;

    // Full-width product straight from the operand ports; the low 2W bits of
    // the extended operands' product are the correct signed/unsigned result.
    always_comb begin
        if (op_i[0]) begin
            ext_a = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i};
            ext_b = {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
        end else begin
            ext_a = {{DATA_WIDTH{1'b0}}, a_i};
            ext_b = {{DATA_WIDTH{1'b0}}, b_i};
        end
        fast_prod = ext_a * ext_b;
    end
`endif

    mult_div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .is_div (op_is_div(op_q)),
        .acc_hi (acc_hi_q),
        .acc_lo (acc_lo_q),
        .opnd   (opnd_q),
        .next_hi(step_hi),
        .next_lo(step_lo)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush returns any state to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULT_DIV_FAST_MULT_EN
                    state_d = op_is_div(md_op_e'(op_i)) ? PREP : FIX;
`else
                    state_d = PREP;
`endif
                end
            end
            PREP:    state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    // Operand magnitudes and signs, meaningful while in PREP.
    always_comb begin
        sign_a = op_is_signed(op_q) & opnd_q[DATA_WIDTH-1];
        sign_b = op_is_signed(op_q) & acc_lo_q[DATA_WIDTH-1];
        abs_a  = sign_a ? -opnd_q   : opnd_q;
        abs_b  = sign_b ? -acc_lo_q : acc_lo_q;
    end

    // Operand capture, sign setup and iteration datapath.
    // Capture always parks a in opnd_q and b in acc_lo_q; PREP then swaps them
    // for divide so opnd_q is the divisor and acc_lo_q the dividend.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MULTU;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= md_op_e'(op_i);
`ifdef MULT_DIV_FAST_MULT_EN
                        if (!op_is_div(md_op_e'(op_i))) begin
                            acc_hi_q <= fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                            acc_lo_q <= fast_prod[DATA_WIDTH-1:0];
                            neg_lo_q <= 1'b0;
                            neg_hi_q <= 1'b0;
                            dbz_q    <= 1'b0;
                        end else
`endif
                        begin
                            opnd_q   <= a_i;
                            acc_lo_q <= b_i;
                        end
                    end
                end
                PREP: begin
                    acc_hi_q <= '0;
                    cnt_q    <= '0;
                    neg_lo_q <= sign_a ^ sign_b;
                    if (op_is_div(op_q)) begin
                        opnd_q   <= abs_b;
                        acc_lo_q <= abs_a;
                        neg_hi_q <= sign_a;
                        dbz_q    <= (acc_lo_q == '0);
                    end else begin
                        opnd_q   <= abs_a;
                        acc_lo_q <= abs_b;
                        neg_hi_q <= sign_a ^ sign_b;
                        dbz_q    <= 1'b0;
                    end
                end
                CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sign-corrected results. With a zero divisor the iteration leaves the
    // dividend magnitude as remainder, so sign correction restores the
    // original a in HI; only LO needs forcing to all ones.
    always_comb begin
        prod = {acc_hi_q, acc_lo_q};
        if (neg_lo_q) prod = -prod;
        if (op_is_div(op_q)) begin
            res_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
            res_lo = dbz_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
        end else begin
            res_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
            res_lo = prod[DATA_WIDTH-1:0];
        end
    end

    // HI/LO: MTHI/MTLO only in IDLE, operation results in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == IDLE) begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
        end else if ((state_q == FIX) && !flush_i) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end
    end

    // Registered busy/done status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == FIX) && !flush_i;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: randomized and directed operations
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        hi_we_i = 1'b0;
    logic        lo_we_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start_i(start_i),
        .op_i   (op_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .hi_we_i(hi_we_i),
        .lo_we_i(lo_we_i),
        .wdata_i(wdata_i),
        .flush_i(flush_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned due;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned op_latency(input md_op_e op);
`ifdef MULT_DIV_FAST_MULT_EN
        if (!op[1]) return 1;
`endif
        return 34;
    endfunction

    // Reference results from ordinary integer arithmetic.
    function automatic exp_t model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] up;
        longint      sp;
        int          sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = up;
                e.tag = "multu";
            end
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {e.hi, e.lo} = sp;
                e.tag = "mult";
            end
            OP_DIVU: begin
                e.tag = "divu";
                if (b == 0) begin e.hi = a; e.lo = '1; end
                else begin e.hi = a % b; e.lo = a / b; end
            end
            default: begin
                e.tag = "div";
                if (b == 0) begin e.hi = a; e.lo = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'h0; e.lo = 32'h8000_0000;
                end else begin
                    e.hi = sa % sb; e.lo = sa / sb;
                end
            end
        endcase
        e.due = 0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && done_o === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pending op", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, "_hi"}, {32'b0, hi_o}, {32'b0, e.hi});
                chk({e.tag, "_lo"}, {32'b0, lo_o}, {32'b0, e.lo});
                chk({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no end of run expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            tick();
            n++;
        end
        if (busy_o) chk("idle_timeout", {63'b0, busy_o}, 64'd0);
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        wait_idle();
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        if (push) begin
            e = model(op, a, b);
            e.due = cyc + 1 + op_latency(op);
            sbq.push_back(e);
        end
        tick();
        start_i = 1'b0;
        chk("busy_after_start", {63'b0, busy_o}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        md_op_e rop;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_hi", {32'b0, hi_o}, 64'd0);
        chk("reset_lo", {32'b0, lo_o}, 64'd0);
        chk("reset_busy", {63'b0, busy_o}, 64'd0);
        chk("reset_done", {63'b0, done_o}, 64'd0);

        // MTHI / MTLO visible the following cycle
        hi_we_i = 1'b1; wdata_i = 32'h0000_AAAA;
        tick();
        hi_we_i = 1'b0;
        chk("mthi", {32'b0, hi_o}, 64'h0000_AAAA);
        lo_we_i = 1'b1; wdata_i = 32'h0000_5555;
        tick();
        lo_we_i = 1'b0;
        chk("mtlo", {32'b0, lo_o}, 64'h0000_5555);
        chk("mtlo_keeps_hi", {32'b0, hi_o}, 64'h0000_AAAA);

        // Flush mid-multiply, with an MTHI attempt while busy
        issue(OP_MULTU, 32'd7, 32'd6, 1'b0);
        hi_we_i = 1'b1; wdata_i = 32'h0000_1234;
        tick();
        hi_we_i = 1'b0;
        chk("mthi_busy_ignored", {32'b0, hi_o}, 64'h0000_AAAA);
        repeat (8) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_busy_low", {63'b0, busy_o}, 64'd0);
        repeat (40) tick();
        chk("flush_hi", {32'b0, hi_o}, 64'h0000_AAAA);
        chk("flush_lo", {32'b0, lo_o}, 64'h0000_5555);

        // Directed cases, issued back to back
        issue(OP_MULTU, 32'd7, 32'd6, 1'b1);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        issue(OP_DIVU, 32'h0000_1234, 32'd0, 1'b1);
        issue(OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // MTHI together with start: write lands, result overwrites later
        wait_idle();
        hi_we_i = 1'b1; wdata_i = 32'h0000_DEAD;
        issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
        hi_we_i = 1'b0;
        chk("mt_with_start", {32'b0, hi_o}, 64'h0000_DEAD);

        // Randomized operations, some with ignored start requests while busy
        for (int i = 0; i < 60; i++) begin
            rop = md_op_e'(2'($urandom_range(0, 3)));
            issue(rop, pick(), pick(), 1'b1);
            if (op_latency(rop) > 4 && $urandom_range(0, 3) == 0) begin
                start_i = 1'b1;
                op_i    = 2'($urandom_range(0, 3));
                a_i     = $urandom;
                b_i     = $urandom;
                repeat (3) tick();
                start_i = 1'b0;
            end
        end

        // Reset in the middle of a divide
        wait_idle();
        tick();
        hi_we_i = 1'b1; wdata_i = 32'h0000_0077;
        tick();
        hi_we_i = 1'b0;
        issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
        repeat (19) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_hi", {32'b0, hi_o}, 64'd0);
        chk("async_reset_lo", {32'b0, lo_o}, 64'd0);
        chk("async_reset_busy", {63'b0, busy_o}, 64'd0);
        chk("async_reset_done", {63'b0, done_o}, 64'd0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        chk("post_reset_idle", {63'b0, busy_o}, 64'd0);

        // A clean operation after reset
        issue(OP_DIVU, 32'd1000, 32'd3, 1'b1);
        wait_idle();
        repeat (3) tick();
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
